adder8_mw_seq: RTL and testbench



---
 rtl/adder8_mw_seq.sv | 112 +++++++++++
 tb/tb_adder8_mw_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/adder8_mw_seq.sv
// Multi-word add/subtract sequencer: drives one shared W-bit adder slice per cycle, LS slice first.
// Latency: accept at edge N, out_valid after edge N+NWORDS; holds results until out_ready, in_ready low while busy.
module adder8_mw_seq #(
    parameter int W      = 8,
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W*NWORDS-1:0]   in_a,
    input  logic [W*NWORDS-1:0]   in_b,
    input  logic                  in_sub,
    input  logic                  in_cin,
    output logic [W-1:0]          add_a,
    output logic [W-1:0]          add_b,
    output logic                  add_cin,
    input  logic [W-1:0]          add_s,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*NWORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  busy
);
    localparam int N  = W * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            w_last;
    logic            w_ovf;

    assign w_last = (r_idx == IW'(NWORDS - 1));
    // r_b already holds the inverted operand for subtraction, so one rule covers both ops.
    assign w_ovf  = (r_a[N-1] == r_b[N-1]) && (r_sum[N-1] != r_a[N-1]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        out_ovf   = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                add_a   = r_a[int'(r_idx)*W +: W];
                add_b   = r_b[int'(r_idx)*W +: W];
                add_cin = r_carry;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = r_sum;
                out_cout  = r_carry;
                out_ovf   = w_ovf;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_sum   <= '0;
                        r_carry <= in_sub ? 1'b1 : in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx)*W +: W] <= add_s;
                    r_carry                   <= add_cout;
                    r_idx                     <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder8_mw_seq.sv
// Directed bench for adder8_mw_seq with a behavioural 8-bit adder slice attached.
module tb_adder8_mw_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sub, in_cin;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_cout, out_ovf, busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic cin_log [0:31];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    adder8_mw_seq #(.W(8), .NWORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin, input logic [31:0] es,
                          input logic ec, input logic eo);
        int cnt;
        in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            cin_log[cnt] = add_cin;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 64'(cnt), 64'd5);
        check({tag, "_sum"}, 64'(out_sum), 64'(es));
        check({tag, "_cout"}, 64'(out_cout), 64'(ec));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
        check({tag, "_vld_after"}, 64'(out_valid), 64'd0);
    endtask

    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic        bsub [3];
    logic [31:0] bs [3];
    int          tv [3];

    initial begin
        int k, n, cyc;
        logic took;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        check("cin_slice0", 64'(cin_log[1]), 64'd0);
        check("cin_slice1", 64'(cin_log[2]), 64'd1);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("add_cin", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0);

        // Backpressure: foreign in_valid held high through RUN and DONE must not be taken.
        in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_sub = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555;
        check("bp_busy_run", 64'(busy), 64'd1);
        check("bp_rdy_run", 64'(in_ready), 64'd0);
        repeat (4) @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_sum", 64'(out_sum), 64'h2345_6789);
            check("bp_hold_rdy", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel_rdy", 64'(in_ready), 64'd1);
        check("bp_rel_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("bp_no_queue", 64'({busy, out_valid}), 64'd0);

        // Reset while slice 2 is on the adder, with a carry in flight.
        in_a = 32'h00AB_FFFF; in_b = 32'h0000_0001; in_sub = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_add_a", 64'(add_a), 64'hAB);
        check("mid_add_cin", 64'(add_cin), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rdy", 64'(in_ready), 64'd1);
        check("mid_rst_outs", 64'({out_valid, out_sum, out_cout, out_ovf}), 64'd0);
        check("mid_rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        run_op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Back-to-back stream with in_valid held high.
        ba[0] = 32'd10;         bb[0] = 32'd20;         bsub[0] = 1'b0; bs[0] = 32'd30;
        ba[1] = 32'd100;        bb[1] = 32'd1;          bsub[1] = 1'b1; bs[1] = 32'd99;
        ba[2] = 32'hDEAD_BEEF;  bb[2] = 32'h1111_1111;  bsub[2] = 1'b0; bs[2] = 32'hEFBE_D000;
        k = 0; n = 0; cyc = 0;
        out_ready = 1'b1; in_cin = 1'b0;
        in_a = ba[0]; in_b = bb[0]; in_sub = bsub[0]; in_valid = 1'b1;
        while (n < 3 && cyc < 100) begin
            took = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (took) begin
                k++;
                if (k < 3) begin
                    in_a = ba[k]; in_b = bb[k]; in_sub = bsub[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b_sum", 64'(out_sum), 64'(bs[n]));
                tv[n] = cyc;
                n++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(n), 64'd3);
        if (n == 3) begin
            check("b2b_gap01", 64'(tv[1] - tv[0]), 64'd6);
            check("b2b_gap12", 64'(tv[2] - tv[1]), 64'd6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
